// File: rtl/cmd_defines_pkg.sv
// Shared command-header definitions for the cmd_tx serializer and cmd_rx decoder.
// Holds the word-size codes, header bit positions, header length and the control-byte builder.
// Pure definitions: no state, no timing.
package cmd_defines_pkg;

    // Word-size codes carried in the control byte; code 3 is reserved and passed through as-is
    localparam logic [1:0] CMD_WSIZE_1BYTE = 2'd0;
    localparam logic [1:0] CMD_WSIZE_2BYTE = 2'd1;
    localparam logic [1:0] CMD_WSIZE_4BYTE = 2'd2;

    // Control-byte (header byte 0) bit positions
    localparam int CMD_HDR_WR_BIT       = 7;
    localparam int CMD_HDR_AINCR_BIT    = 6;
    localparam int CMD_HDR_WSIZE_HI_BIT = 5;
    localparam int CMD_HDR_WSIZE_LO_BIT = 4;

    // Header length in bytes and the width of the byte index that walks it
    localparam int         CMD_HDR_LEN  = 6;
    localparam int         CMD_CNT_W    = 3;
    localparam logic [2:0] CMD_CNT_LAST = 3'(CMD_HDR_LEN - 1);

    // Header byte indices, in transmission order
    localparam logic [2:0] CMD_IDX_CTRL   = 3'd0;
    localparam logic [2:0] CMD_IDX_WCOUNT = 3'd1;
    localparam logic [2:0] CMD_IDX_ADDR3  = 3'd2;
    localparam logic [2:0] CMD_IDX_ADDR2  = 3'd3;
    localparam logic [2:0] CMD_IDX_ADDR1  = 3'd4;
    localparam logic [2:0] CMD_IDX_ADDR0  = 3'd5;

    // Build the control byte; the low nibble is always zero
    function automatic logic [7:0] cmd_hdr_byte0(input logic       wr,
                                                 input logic       aincr,
                                                 input logic [1:0] wsize);
        logic [7:0] b;
        b = 8'h00;
        b[CMD_HDR_WR_BIT]                             = wr;
        b[CMD_HDR_AINCR_BIT]                          = aincr;
        b[CMD_HDR_WSIZE_HI_BIT:CMD_HDR_WSIZE_LO_BIT]  = wsize;
        return b;
    endfunction

endpackage

// File: rtl/cmd_tx.sv
// Serializes one memory request into a 6-byte header (ctrl, wcount, addr MSB..LSB) on a byte stream.
// Zero latency: byte0 appears the cycle i_mreq_valid rises; one byte per accepted handshake, 6 cycles/request.
// Backpressure: i_tx_ready low holds the byte index and data; o_mreq_ready pulses only on the last-byte handshake.
module cmd_tx
    import cmd_defines_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic        i_mreq_valid,
    output logic        o_mreq_ready,
    input  logic        i_mreq_wr,
    input  logic [1:0]  i_mreq_wsize,
    input  logic        i_mreq_aincr,
    input  logic [7:0]  i_mreq_wcount,
    input  logic [31:0] i_mreq_addr
);

    logic [CMD_CNT_W-1:0] cnt_q;
    logic [CMD_CNT_W-1:0] cnt_d;
    logic                 tx_hs;
    logic                 cnt_last;

    // Handshake qualification and next byte index; wraps to 0 after the last byte so a held request restarts cleanly
    always_comb begin
        o_tx_valid   = i_mreq_valid && !i_rst;
        tx_hs        = o_tx_valid && i_tx_ready;
        cnt_last     = (cnt_q == CMD_CNT_LAST);
        o_mreq_ready = tx_hs && cnt_last;
        cnt_d        = cnt_q;
        if (tx_hs) begin
            cnt_d = cnt_last ? '0 : cnt_q + 3'd1;
        end
    end

    // Byte index register; reset returns to byte0 even mid-header
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Header byte mux from the live request fields; the requester holds them stable while valid
    always_comb begin
        o_tx_data = 8'h00;
        case (cnt_q)
            CMD_IDX_CTRL:   o_tx_data = cmd_hdr_byte0(i_mreq_wr, i_mreq_aincr, i_mreq_wsize);
            CMD_IDX_WCOUNT: o_tx_data = i_mreq_wcount;
            CMD_IDX_ADDR3:  o_tx_data = i_mreq_addr[31:24];
            CMD_IDX_ADDR2:  o_tx_data = i_mreq_addr[23:16];
            CMD_IDX_ADDR1:  o_tx_data = i_mreq_addr[15:8];
            CMD_IDX_ADDR0:  o_tx_data = i_mreq_addr[7:0];
            default:        o_tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cmd_tx.sv
// Scoreboard bench for cmd_tx: the driver pushes expected header bytes, a negedge monitor pops and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every wait is bounded by a cycle budget; an expired budget counts as a failed check.
module tb_cmd_tx;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        i_mreq_valid;
    logic        o_mreq_ready;
    logic        i_mreq_wr;
    logic [1:0]  i_mreq_wsize;
    logic        i_mreq_aincr;
    logic [7:0]  i_mreq_wcount;
    logic [31:0] i_mreq_addr;

    cmd_tx dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .i_mreq_valid (i_mreq_valid),
        .o_mreq_ready (o_mreq_ready),
        .i_mreq_wr    (i_mreq_wr),
        .i_mreq_wsize (i_mreq_wsize),
        .i_mreq_aincr (i_mreq_aincr),
        .i_mreq_wcount(i_mreq_wcount),
        .i_mreq_addr  (i_mreq_addr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   hs_cnt   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    bit   rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference model: the 6 header bytes computed arithmetically from the request fields
    task automatic push_hdr(input logic wr, input logic [1:0] wsize, input logic aincr,
                            input logic [7:0] wcount, input logic [31:0] addr);
        int   b[6];
        exp_t e;
        b[0] = int'(wr) * 128 + int'(aincr) * 64 + int'(wsize) * 16;
        b[1] = int'(wcount);
        for (int i = 0; i < 4; i++) begin
            b[2 + i] = int'((addr >> (24 - 8 * i)) & 32'hFF);
        end
        for (int i = 0; i < 6; i++) begin
            e.data = 8'(b[i]);
            e.last = (i == 5);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares every presented byte against the scoreboard head
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("valid_in_reset", {31'd0, o_tx_valid}, 32'd0);
            chk("mreq_ready_in_reset", {31'd0, o_mreq_ready}, 32'd0);
        end else if (!i_mreq_valid) begin
            chk("idle_valid_ready", {30'd0, o_tx_valid, o_mreq_ready}, 32'd0);
        end else if (!o_tx_valid) begin
            chk("tx_valid_follows_req", 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
        end else begin
            chk("tx_data", {24'd0, o_tx_data}, {24'd0, exp_q[0].data});
            if (i_tx_ready) begin
                chk("mreq_ready_on_hs", {31'd0, o_mreq_ready}, {31'd0, exp_q[0].last});
                if (exp_q[0].last) done_cnt++;
                void'(exp_q.pop_front());
                hs_cnt++;
            end else begin
                chk("mreq_ready_stalled", {31'd0, o_mreq_ready}, 32'd0);
            end
        end
    end

    task automatic cycle();
        @(posedge i_clk);
        #1;
        cyc++;
        if (rnd_ready) i_tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_req(input logic wr, input logic [1:0] wsize, input logic aincr,
                             input logic [7:0] wcount, input logic [31:0] addr);
        i_mreq_wr     = wr;
        i_mreq_wsize  = wsize;
        i_mreq_aincr  = aincr;
        i_mreq_wcount = wcount;
        i_mreq_addr   = addr;
        i_mreq_valid  = 1'b1;
        push_hdr(wr, wsize, aincr, wcount, addr);
    endtask

    task automatic wait_done(input string nm);
        int base;
        int budget;
        base   = done_cnt;
        budget = 400;
        while (done_cnt == base && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input int n);
        int base;
        int budget;
        base   = hs_cnt;
        budget = 400;
        while (hs_cnt < base + n && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) chk("wait_hs_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        i_rst = 1'b1; i_tx_ready = 1'b1; i_mreq_valid = 1'b1;
        i_mreq_wr = 1'b0; i_mreq_wsize = 2'd0; i_mreq_aincr = 1'b0;
        i_mreq_wcount = 8'd0; i_mreq_addr = 32'd0;
        // Reset with a request pending: monitor requires valid/ready low
        repeat (3) cycle();
        i_mreq_valid = 1'b0;
        cycle();
        i_rst = 1'b0;
        repeat (2) cycle();

        // Read request, ready high: exactly 6 cycles
        t0 = cyc;
        start_req(1'b0, 2'd1, 1'b1, 8'd5, 32'h1234_5678);
        wait_done("read");
        chk("read_cycles", 32'(cyc - t0), 32'd6);
        i_mreq_valid = 1'b0;
        repeat (2) cycle();

        // Write request, stall 10 cycles after 2 bytes
        start_req(1'b1, 2'd1, 1'b1, 8'd5, 32'h4321_1234);
        wait_hs(2);
        i_tx_ready = 1'b0;
        repeat (10) cycle();
        i_tx_ready = 1'b1;
        wait_done("stall");
        i_mreq_valid = 1'b0;
        cycle();

        // Ready low before valid rises, held 12 cycles
        i_tx_ready = 1'b0;
        cycle();
        t0 = cyc;
        start_req(1'b1, 2'd1, 1'b1, 8'd5, 32'h4321_1234);
        repeat (12) cycle();
        i_tx_ready = 1'b1;
        wait_done("pre_stall");
        chk("pre_stall_cycles", 32'(cyc - t0), 32'd18);
        i_mreq_valid = 1'b0;
        cycle();

        // Two back-to-back requests with valid held: 12 cycles, no bubble
        t0 = cyc;
        start_req(1'b0, 2'd2, 1'b0, 8'hA5, 32'hDEAD_BEEF);
        wait_done("b2b_first");
        start_req(1'b1, 2'd0, 1'b1, 8'h3C, 32'h0BAD_F00D);
        wait_done("b2b_second");
        chk("b2b_cycles", 32'(cyc - t0), 32'd12);
        i_mreq_valid = 1'b0;
        cycle();

        // Reset at cnt=3 with the request still valid: header restarts at byte0
        start_req(1'b1, 2'd2, 1'b1, 8'h77, 32'hCAFE_0123);
        wait_hs(3);
        i_rst = 1'b1;
        exp_q.delete();
        push_hdr(1'b1, 2'd2, 1'b1, 8'h77, 32'hCAFE_0123);
        repeat (2) cycle();
        i_rst = 1'b0;
        wait_done("reset_restart");
        i_mreq_valid = 1'b0;
        cycle();

        // Valid dropped mid-header: index holds and resumes at the same byte
        start_req(1'b0, 2'd3, 1'b0, 8'h10, 32'h8765_4321);
        wait_hs(2);
        i_mreq_valid = 1'b0;
        repeat (3) cycle();
        i_mreq_valid = 1'b1;
        wait_done("valid_drop");
        i_mreq_valid = 1'b0;
        cycle();

        // Field sweep over every wr/aincr/wsize combination
        for (int k = 0; k < 16; k++) begin
            start_req(k[3], k[1:0], k[2], 8'(k * 17), $urandom);
            wait_done("sweep");
            i_mreq_valid = 1'b0;
            cycle();
        end

        // Randomized requests with random backpressure and random back-to-back holding
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            start_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
            wait_done("random");
            if ($urandom_range(0, 1) == 0) begin
                i_mreq_valid = 1'b0;
                repeat ($urandom_range(1, 3)) cycle();
            end
        end
        i_mreq_valid = 1'b0;
        rnd_ready = 1'b0;
        repeat (3) cycle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/cmd_tx.md
Name: cmd_tx

Overview:
- Serializes one memory-request command (write flag, word size, address-increment flag, word count, 32-bit address) into a fixed 6-byte header on a byte-wide valid/ready stream.
- Sits between the command/request generator and the byte transport (UART/FIFO/USB link) toward the host-side command decoder.
- Request handshake completes only when the last header byte has been accepted downstream.

Parameters:
- None. Field encodings come from the shared command package.

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- o_tx_data  out  8  current header byte
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  downstream accepts byte when high with o_tx_valid
- i_mreq_valid  in  1  request present; held with fields stable until o_mreq_ready
- o_mreq_ready  out  1  request consumed (one-cycle, on last-byte handshake)
- i_mreq_wr  in  1  1 = write, 0 = read
- i_mreq_wsize  in  2  word size code (CMD_WSIZE_*)
- i_mreq_aincr  in  1  address auto-increment enable
- i_mreq_wcount  in  8  word count
- i_mreq_addr  in  32  start address

Behaviour:
- Internal byte index cnt, 3 bits, range 0..5; reset value 0. No other state.
- Header layout, emitted in order:
  - byte0 = {wr, aincr, wsize[1:0], 4'b0000}
  - byte1 = wcount
  - byte2..5 = addr[31:24], addr[23:16], addr[15:8], addr[7:0] (MSB first)
- o_tx_data = byte[cnt], combinational mux from the live request inputs. Fields are not latched; the requester must hold them stable while i_mreq_valid is high.
- o_tx_valid = i_mreq_valid && !i_rst. Zero latency: byte0 is presented in the same cycle valid rises.
- Byte handshake = o_tx_valid && i_tx_ready.
  - On handshake with cnt<5: cnt <= cnt+1.
  - On handshake with cnt==5: cnt <= 0.
- o_mreq_ready = o_tx_valid && i_tx_ready && (cnt==5), combinational. It is high exactly in the cycle the last byte transfers.
- No handshake: cnt holds and o_tx_data is stable. Back-pressure of any length on any byte is allowed.
- Valid held high after ready: the next request starts at byte0 in the following cycle. There are no idle bubbles between back-to-back requests.
- i_mreq_valid dropped mid-header is a protocol violation. Required behaviour: cnt holds, o_tx_valid=0, and the header resumes at the same index when valid returns.
- Reset (any time, including mid-header):
  - cnt <= 0.
  - o_tx_valid=0 and o_mreq_ready=0 while i_rst is high.
  - After reset, a still-valid request restarts from byte0.
- Throughput: 6 cycles per request with i_tx_ready tied high.
- wsize code 3 is reserved and passed through unchanged.

Decomposition:
- Shared package/include cmd_defines holds:
  - CMD_WSIZE_1BYTE=2'd0, CMD_WSIZE_2BYTE=2'd1, CMD_WSIZE_4BYTE=2'd2 (3 reserved)
  - header bit positions (WR=7, AINCR=6, WSIZE=5:4)
  - CMD_HDR_LEN=6
- The matching receive-side decoder (cmd_rx) uses the same package.
- No sub-module needed; a single module with a counter and a byte mux.

Test Plan:
- Read request, tx_ready=1: wr=0, wsize=CMD_WSIZE_2BYTE, aincr=1, wcount=5, addr=0x12345678.
  -> bytes 0x50,0x05,0x12,0x34,0x56,0x78 on 6 consecutive cycles; mreq_ready high only in the cycle of 0x78.
- Write request with mid-stream stall: wr=1, same fields, addr=0x43211234; drop tx_ready for 10 cycles after 2 bytes.
  -> bytes 0xD0,0x05,0x43,0x21,0x12,0x34; data stable during the stall; no byte lost or duplicated; one mreq_ready pulse.
- tx_ready low before valid rises, held 12 cycles.
  -> 0xD0 presented and held for 12 cycles; full header sent after release; single mreq_ready pulse.
- Valid held continuously for 2 requests.
  -> 12 bytes back-to-back; second header begins the cycle after the first mreq_ready.
- Reset asserted at cnt=3.
  -> tx_valid=0 during reset; afterwards the header restarts at byte0.
- Field sweep across every wsize code and wr/aincr combination.
  -> byte0 equals {wr,aincr,wsize,4'b0} in each case.
